// File: rtl/komut_issue_ctrl.sv
// komut_issue_ctrl: in-order issue of buffered instructions with a scoreboard hazard check; illegal opcodes are dropped and counted.
// Optional macro WB_BYPASS_EN lets a stalled head issue in its writeback cycle.
module komut_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_komut,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [31:0]      iss_komut,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic             busy,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, CHECK, STALL, DROP} st_t;

    st_t            st, st_n;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  rp, wp, rp1;
    logic [AW:0]    cnt, cnt_n;
    logic [31:0]    sb, sb_n, clr_v, set_v, head, head_n;
    logic           go, issue, pop, push;

    function automatic logic legal(input logic [31:0] k);
        return k[6:0] == 7'h01 || k[6:0] == 7'h03 || k[6:0] == 7'h07 || k[6:0] == 7'h0f;
    endfunction

    function automatic logic writes(input logic [31:0] k);
        return k[6:0] == 7'h01 || k[6:0] == 7'h03 || k[6:0] == 7'h07;
    endfunction

    // Register 0 is masked so it can never block an instruction.
    function automatic logic haz(input logic [31:0] k, input logic [31:0] s);
        logic r1, r2;
        r1 = k[6:0] == 7'h01 || k[6:0] == 7'h03 || k[6:0] == 7'h0f;
        r2 = k[6:0] == 7'h01 || k[6:0] == 7'h0f;
        return (r1 && k[19:15] != 5'd0 && s[k[19:15]]) ||
               (r2 && k[24:20] != 5'd0 && s[k[24:20]]) ||
               (writes(k) && k[11:7] != 5'd0 && s[k[11:7]]);
    endfunction

    function automatic st_t classify(input logic ne, input logic [31:0] k, input logic [31:0] s);
        return !ne ? IDLE : !legal(k) ? DROP : haz(k, s) ? STALL : CHECK;
    endfunction

    always_comb begin
        head  = mem[rp];
        rp1   = rp + 1'b1;
        clr_v = (wb_valid && wb_rd != 5'd0) ? (32'd1 << wb_rd) : 32'd0;
`ifdef WB_BYPASS_EN
        go    = st == CHECK || (st == STALL && !haz(head, sb & ~clr_v));
`else
        go    = st == CHECK;
`endif
        issue = go && iss_ready;
        pop   = issue || st == DROP;
        push  = in_valid && in_ready;
        set_v = (issue && writes(head) && head[11:7] != 5'd0) ? (32'd1 << head[11:7]) : 32'd0;
        sb_n  = (sb & ~clr_v) | set_v;
        cnt_n = cnt + (AW+1)'(push) - (AW+1)'(pop);
        // The state register tracks what next cycle's head will look like against next cycle's scoreboard.
        head_n = pop ? (cnt > (AW+1)'(1) ? mem[rp1] : in_komut) : (cnt == '0 ? in_komut : head);
        st_n   = classify(cnt_n != '0, head_n, sb_n);
    end

    assign in_ready  = cnt < (AW+1)'(DEPTH);
    assign iss_valid = go;
    assign iss_komut = head;
    assign busy      = cnt != '0 || sb != 32'd0;
    assign state     = go ? CHECK : st;

    always_ff @(posedge clk)
        if (push) mem[wp] <= in_komut;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            rp      <= '0;
            wp      <= '0;
            cnt     <= '0;
            sb      <= 32'd0;
            err_cnt <= '0;
        end else begin
            st  <= st_n;
            cnt <= cnt_n;
            sb  <= sb_n;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp1;
            if (st == DROP && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_komut_issue_ctrl.sv
// tb_komut_issue_ctrl: directed checks of issue, stall, drop, full-FIFO and reset behaviour.
module tb_komut_issue_ctrl;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready, iss_valid, iss_ready = 0, wb_valid = 0, busy;
    logic [31:0] in_komut = 0, iss_komut;
    logic [4:0]  wb_rd = 0;
    logic [7:0]  err_cnt;
    logic [1:0]  state;
    int checks = 0, errors = 0;

    komut_issue_ctrl #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_komut(in_komut),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_komut(iss_komut),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .busy(busy), .err_cnt(err_cnt), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(); tick();
        rst = 0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state, 0);
        chk("rst_err", err_cnt, 0);

        iss_ready = 1; in_valid = 1; in_komut = 32'h00208181;
        tick();
        in_valid = 0; #1;
        chk("t1_iss_valid", iss_valid, 1);
        chk("t1_komut", iss_komut, 32'h00208181);
        chk("t1_state", state, 1);
        tick();
        chk("t1_busy_sb3", busy, 1);
        chk("t1_idle", state, 0);

        in_valid = 1; in_komut = 32'h00018201;
        tick();
        in_valid = 0; #1;
        chk("t2_stall", state, 2);
        chk("t2_stall_valid", iss_valid, 0);
        tick();
        chk("t2_still_stall", state, 2);
        wb_valid = 1; wb_rd = 3; #1;
`ifdef WB_BYPASS_EN
        chk("t2_bypass_valid", iss_valid, 1);
        tick();
        wb_valid = 0; #1;
`else
        chk("t2_wb_cycle_valid", iss_valid, 0);
        tick();
        wb_valid = 0; #1;
        chk("t2_issue_state", state, 1);
        chk("t2_issue_komut", iss_komut, 32'h00018201);
        tick();
`endif
        chk("t2_done_idle", state, 0);
        wb_valid = 1; wb_rd = 4;
        tick();
        wb_valid = 0; #1;
        chk("t2_clean_busy", busy, 0);

        in_valid = 1; in_komut = 32'h0000007f;
        tick();
        in_valid = 0; #1;
        chk("t3_drop_state", state, 3);
        chk("t3_drop_valid", iss_valid, 0);
        tick();
        chk("t3_err1", err_cnt, 1);
        chk("t3_after_drop", state, 0);
        chk("t3_busy", busy, 0);
        in_valid = 1;
        for (int i = 0; i < 253; i++) tick();
        in_valid = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("t3_err254", err_cnt, 254);
        in_valid = 1;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("t3_err_sat", err_cnt, 255);

        iss_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1; in_komut = (32'(i) << 28) | 32'h7; #1;
            chk($sformatf("t4_in_ready%0d", i), in_ready, (i <= 4) ? 1 : 0);
            if (i == 2) chk("t4_hold_komut", iss_komut, 32'h10000007);
            tick();
        end
        iss_ready = 1; #1;
        chk("t4_full_pop_ready", in_ready, 0);
        chk("t4_w1", iss_komut, 32'h10000007);
        chk("t4_v1", iss_valid, 1);
        tick();
        chk("t4_ready_after_pop", in_ready, 1);
        chk("t4_w2", iss_komut, 32'h20000007);
        tick();
        in_valid = 0; #1;
        chk("t4_w3", iss_komut, 32'h30000007);
        tick();
        chk("t4_w4", iss_komut, 32'h40000007);
        tick();
        chk("t4_w5", iss_komut, 32'h50000007);
        chk("t4_v5", iss_valid, 1);
        tick();
        chk("t4_drained", state, 0);

        in_valid = 1; in_komut = 32'h12345287;
        tick();
        in_valid = 0; wb_valid = 1; wb_rd = 5; #1;
        chk("t5_issue", iss_valid, 1);
        tick();
        wb_valid = 0; #1;
        chk("t5_set_wins", busy, 1);
        in_valid = 1; in_komut = 32'h00000287;
        tick();
        in_valid = 0; #1;
        chk("t5_waw_stall", state, 2);
        wb_valid = 1; wb_rd = 5;
        tick();
        wb_valid = 0;
        tick();
        chk("t5_reissue_idle", state, 0);
        chk("t5_sb5_again", busy, 1);
        wb_valid = 1; wb_rd = 5;
        tick();
        wb_valid = 0; #1;
        chk("t5_cleared", busy, 0);

        in_valid = 1; in_komut = 32'h00208181;
        tick();
        in_valid = 0;
        tick();
        iss_ready = 0;
        in_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            in_komut = (32'(i) << 28) | 32'h7;
            tick();
        end
        in_valid = 0; #1;
        chk("t6_pre_valid", iss_valid, 1);
        chk("t6_pre_busy", busy, 1);
        #1 rst = 1;
        #1;
        chk("t6_iss_valid", iss_valid, 0);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_busy", busy, 0);
        chk("t6_state", state, 0);
        chk("t6_err", err_cnt, 0);
        tick();
        rst = 0;
        tick();
        chk("t6_post_idle", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
